cordic_sched: RTL and testbench

Two-requester scheduler for the pipelined CORDIC rotation core (`cordic_updated`). It round-robin-arbitrates rotation requests onto the core's single `x0`/`y0`/`z0` issue port, one per clock. It tracks every in-flight operation in a tag shift register matched to the core latency, and routes each `X`/`Y` result back to the requester that issued it. It sits between the angle-producing front ends and the CORDIC pipeline, and also provides a flush/drain sequence for reconfiguration.

---
 rtl/cordic_sched.sv | 166 ++++++++++++++++
 tb/tb_cordic_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin two-requester issue scheduler for the CORDIC core.
// Optional quadrant fold at issue: define CORDIC_SCHED_QUADRANT_EN.
module cordic_sched #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [WIDTH-1:0] req0_z,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [WIDTH-1:0] req1_z,
  output logic             res0_valid,
  output logic [WIDTH-1:0] res0_x,
  output logic [WIDTH-1:0] res0_y,
  output logic             res1_valid,
  output logic [WIDTH-1:0] res1_x,
  output logic [WIDTH-1:0] res1_y,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy,
  output logic [WIDTH-1:0] cord_x0,
  output logic [WIDTH-1:0] cord_y0,
  output logic [WIDTH-1:0] cord_z0,
  input  logic [WIDTH-1:0] cord_x,
  input  logic [WIDTH-1:0] cord_y
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // One extra stage: stage 0 runs alongside the cord_*0 issue register.
  localparam int DEPTH = LATENCY + 1;

  state_t state, state_nx;
  logic   last;
  logic   take;
  logic   gid;
  logic   accept;
  logic   head_v;
  logic   head_id;

  logic [DEPTH-1:0] trk_v;
  logic [DEPTH-1:0] trk_id;

  logic signed [WIDTH-1:0] sel_x, sel_y, sel_z;
  logic signed [WIDTH-1:0] iss_x, iss_y, iss_z;

  assign busy    = |trk_v;
  assign head_v  = trk_v[DEPTH-1];
  assign head_id = trk_id[DEPTH-1];
  assign accept  = (state != DRAIN) && !flush;

  assign req0_ready = accept && req0_valid && (!req1_valid || last);
  assign req1_ready = accept && req1_valid && (!req0_valid || !last);
  assign take       = req0_ready || req1_ready;
  assign gid        = req1_ready;

  assign sel_x = gid ? req1_x : req0_x;
  assign sel_y = gid ? req1_y : req0_y;
  assign sel_z = gid ? req1_z : req0_z;

`ifdef CORDIC_SCHED_QUADRANT_EN
  localparam logic signed [WIDTH-1:0] PI      = WIDTH'(205887);
  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(102943);

  always_comb begin
    iss_x = sel_x;
    iss_y = sel_y;
    iss_z = sel_z;
    unique case (1'b1)
      (sel_z > HALF_PI): begin
        iss_x = -sel_x;
        iss_y = -sel_y;
        iss_z = sel_z - PI;
      end
      (sel_z < -HALF_PI): begin
        iss_x = -sel_x;
        iss_y = -sel_y;
        iss_z = sel_z + PI;
      end
      default: ;
    endcase
  end
`else
  assign iss_x = sel_x;
  assign iss_y = sel_y;
  assign iss_z = sel_z;
`endif

  always_comb begin
    state_nx   = state;
    flush_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush)     state_nx = DRAIN;
        else if (take) state_nx = RUN;
      end
      RUN: begin
        if (flush)              state_nx = DRAIN;
        else if (!busy && !take) state_nx = IDLE;
      end
      DRAIN: begin
        if (!busy) begin
          flush_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      trk_v   <= '0;
      trk_id  <= '0;
      cord_x0 <= '0;
      cord_y0 <= '0;
      cord_z0 <= '0;
    end else begin
      state  <= state_nx;
      trk_v  <= {trk_v[DEPTH-2:0], take};
      trk_id <= {trk_id[DEPTH-2:0], gid};
      if (take) begin
        last    <= gid;
        cord_x0 <= iss_x;
        cord_y0 <= iss_y;
        cord_z0 <= iss_z;
      end else begin
        cord_x0 <= '0;
        cord_y0 <= '0;
        cord_z0 <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res0_x     <= '0;
      res0_y     <= '0;
      res1_x     <= '0;
      res1_y     <= '0;
    end else begin
      res0_valid <= head_v && !head_id;
      res1_valid <= head_v && head_id;
      if (head_v && !head_id) begin
        res0_x <= cord_x;
        res0_y <= cord_y;
      end
      if (head_v && head_id) begin
        res1_x <= cord_x;
        res1_y <= cord_y;
      end
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: ideal-rotation core stand-in, scoreboard model, vectors.
// Build with CORDIC_SCHED_QUADRANT_EN to exercise the quadrant fold.
module tb_cordic_sched;

  localparam int W = 32;
  localparam int L = 16;
  localparam real KG = 1.6467602581;

  typedef struct {
    int x;
    int y;
    int z;
  } op_t;

  typedef struct {
    bit id;
    int x;
    int y;
    int due;
  } exp_t;

  typedef struct {
    bit v0;
    bit v1;
    bit r0;
    bit r1;
  } arb_vec_t;

  logic         clk = 0;
  logic         rst = 1;
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_x = 0, req0_y = 0, req0_z = 0;
  logic [W-1:0] req1_x = 0, req1_y = 0, req1_z = 0;
  logic         res0_valid, res1_valid;
  logic [W-1:0] res0_x, res0_y, res1_x, res1_y;
  logic         flush = 0;
  logic         flush_done, busy;
  logic [W-1:0] cord_x0, cord_y0, cord_z0;
  logic [W-1:0] cord_x, cord_y;

  int tests = 0;
  int fails = 0;
  int edges = 0;
  int done_cnt = 0;

  exp_t sb[$];
  bit   m_last = 1;
  bit   m_drain = 0;
  op_t  m_c0 = '{0, 0, 0};
  op_t  p0, p1;
  bit   e0, e1, g_r0, g_r1;

  int px[L];
  int py[L];

  cordic_sched #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
    .res0_valid(res0_valid), .res0_x(res0_x), .res0_y(res0_y),
    .res1_valid(res1_valid), .res1_x(res1_x), .res1_y(res1_y),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .cord_x0(cord_x0), .cord_y0(cord_y0), .cord_z0(cord_z0),
    .cord_x(cord_x), .cord_y(cord_y)
  );

  always #5 clk = ~clk;

  function automatic int rot_x(int x, int y, int z);
    real a = real'(z) / 65536.0;
    return $rtoi(KG * (real'(x) * $cos(a) - real'(y) * $sin(a)));
  endfunction

  function automatic int rot_y(int x, int y, int z);
    real a = real'(z) / 65536.0;
    return $rtoi(KG * (real'(y) * $cos(a) + real'(x) * $sin(a)));
  endfunction

  function automatic op_t fold(op_t o);
    op_t r = o;
`ifdef CORDIC_SCHED_QUADRANT_EN
    if (o.z > 102943) r = '{-o.x, -o.y, o.z - 205887};
    else if (o.z < -102943) r = '{-o.x, -o.y, o.z + 205887};
`endif
    return r;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.x = int'($urandom_range(131072)) - 65536;
    o.y = int'($urandom_range(131072)) - 65536;
    o.z = int'($urandom_range(200000)) - 100000;
    return o;
  endfunction

  // Core stand-in: ideal rotation with CORDIC gain, L edges of delay.
  always @(posedge clk) begin
    edges <= edges + 1;
    if (flush_done) done_cnt <= done_cnt + 1;
    px[0] <= rot_x($signed(cord_x0), $signed(cord_y0), $signed(cord_z0));
    py[0] <= rot_y($signed(cord_x0), $signed(cord_y0), $signed(cord_z0));
    for (int i = 1; i < L; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign cord_x = px[L-1];
  assign cord_y = py[L-1];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    tests++;
    if (act > exp + 8 || act < exp - 8) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d+-8", name, act, exp);
    end
  endtask

  task automatic step(input bit v0, input bit v1, input bit fl);
    exp_t h;
    op_t  f;
    bit   done_now, x0v, x1v;
    @(negedge clk);
    x0v = 0;
    x1v = 0;
    h = '{0, 0, 0, 0};
    if (sb.size() > 0 && sb[0].due == edges) begin
      h = sb.pop_front();
      x0v = !h.id;
      x1v = h.id;
    end
    chk("res0_valid", int'(res0_valid), int'(x0v));
    chk("res1_valid", int'(res1_valid), int'(x1v));
    if (x0v) begin
      chk("res0_x", $signed(res0_x), h.x);
      chk("res0_y", $signed(res0_y), h.y);
    end
    if (x1v) begin
      chk("res1_x", $signed(res1_x), h.x);
      chk("res1_y", $signed(res1_y), h.y);
    end
    chk("busy", int'(busy), int'(sb.size() > 0));
    chk("cord_x0", $signed(cord_x0), m_c0.x);
    chk("cord_y0", $signed(cord_y0), m_c0.y);
    chk("cord_z0", $signed(cord_z0), m_c0.z);
    done_now = m_drain && sb.size() == 0;
    chk("flush_done", int'(flush_done), int'(done_now));
    req0_valid = v0;
    req1_valid = v1;
    req0_x = p0.x; req0_y = p0.y; req0_z = p0.z;
    req1_x = p1.x; req1_y = p1.y; req1_z = p1.z;
    flush = fl;
    #1;
    e0 = !fl && !m_drain && v0 && (!v1 || m_last);
    e1 = !fl && !m_drain && v1 && (!v0 || !m_last);
    g_r0 = req0_ready;
    g_r1 = req1_ready;
    chk("req0_ready", int'(g_r0), int'(e0));
    chk("req1_ready", int'(g_r1), int'(e1));
    if (e0 || e1) begin
      m_last = e1;
      f = fold(e1 ? p1 : p0);
      m_c0 = f;
      sb.push_back('{e1, rot_x(f.x, f.y, f.z), rot_y(f.x, f.y, f.z),
                     edges + L + 2});
    end else begin
      m_c0 = '{0, 0, 0};
    end
    if (done_now) m_drain = 0;
    else if (fl) m_drain = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  arb_vec_t tbl[16];
  int       a_edge;

  initial begin
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0};
    tbl[6] = '{1, 1, 0, 1};
    tbl[7] = '{0, 1, 0, 1};
    for (int i = 8; i < 16; i++) tbl[i] = '{1, 1, (i % 2) == 0, (i % 2) == 1};

    p0 = rnd_op();
    p1 = rnd_op();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cord_x0", $signed(cord_x0), 0);
    chk("rst res0_x", $signed(res0_x), 0);
    chk("rst res1_y", $signed(res1_y), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst flush_done", int'(flush_done), 0);
    chk("rst res_valid", int'({res0_valid, res1_valid}), 0);
    rst = 0;

    // Arbitration table, then 8 cycles of both valid alternating 0,1,...
    foreach (tbl[i]) begin
      p0 = rnd_op();
      p1 = rnd_op();
      step(tbl[i].v0, tbl[i].v1, 0);
      chk("tbl ready0", int'(g_r0), int'(tbl[i].r0));
      chk("tbl ready1", int'(g_r1), int'(tbl[i].r1));
    end
    idle(L + 3);

    // Single quarter-turn op from requester 0.
    p0 = '{65536, 0, 102943};
    step(1, 0, 0);
    a_edge = edges + 1;
    idle(L + 3);
    chk_near("q1 res0_x", $signed(res0_x), 0);
    chk_near("q1 res0_y", $signed(res0_y), 107923);
    chk("q1 sb empty", sb.size(), 0);

    // 32-op back-to-back stream from requester 1.
    for (int i = 0; i < 32; i++) begin
      p1 = rnd_op();
      step(0, 1, 0);
      chk("stream accept", int'(g_r1), 1);
    end
    idle(L + 3);

    // Randomised traffic honouring the hold-while-pending rule.
    begin
      bit v0 = 0, v1 = 0;
      for (int i = 0; i < 400; i++) begin
        if (!v0) v0 = ($urandom_range(3) != 0);
        if (!v1) v1 = ($urandom_range(3) != 0);
        step(v0, v1, 0);
        if (e0) begin v0 = 0; p0 = rnd_op(); end
        if (e1) begin v1 = 0; p1 = rnd_op(); end
      end
      idle(L + 3);
    end

    // Flush with 5 ops in flight and both requesters still valid.
    for (int i = 0; i < 5; i++) begin
      p1 = rnd_op();
      step(0, 1, 0);
    end
    done_cnt = 0;
    step(1, 1, 1);
    begin
      int n = 0;
      while (m_drain && n < L + 4) begin
        step(1, 1, 1);
        n++;
      end
    end
    chk("drain finished", int'(m_drain), 0);
    chk("drain results", sb.size(), 0);
    step(1, 1, 0);
    chk("post-drain accept", int'(g_r0 || g_r1), 1);
    chk("flush_done count", done_cnt, 1);
    idle(L + 3);

    // Flush from IDLE: done fires on the following cycle.
    step(0, 0, 1);
    step(0, 0, 0);
    idle(3);

    // Reset with 10 ops in flight.
    for (int i = 0; i < 10; i++) begin
      p0 = rnd_op();
      step(1, 0, 0);
    end
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst cord_x0", $signed(cord_x0), 0);
    chk("mid rst res0_x", $signed(res0_x), 0);
    chk("mid rst res0_y", $signed(res0_y), 0);
    chk("mid rst res1_x", $signed(res1_x), 0);
    req0_valid = 0;
    req1_valid = 0;
    sb.delete();
    m_last = 1;
    m_drain = 0;
    m_c0 = '{0, 0, 0};
    @(negedge clk);
    rst = 0;
    idle(L + 4);

    // Quadrant case: z = 3*pi/2.
    p0 = '{65536, 0, 308830};
    step(1, 0, 0);
    @(posedge clk);
    #1;
`ifdef CORDIC_SCHED_QUADRANT_EN
    chk("fold cord_x0", $signed(cord_x0), -65536);
    chk("fold cord_z0", $signed(cord_z0), 102943);
`else
    chk("pass cord_x0", $signed(cord_x0), 65536);
    chk("pass cord_z0", $signed(cord_z0), 308830);
`endif
    idle(L + 3);
`ifdef CORDIC_SCHED_QUADRANT_EN
    chk_near("fold res0_y", $signed(res0_y), -107923);
`endif
    chk("final sb empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
